// File: rtl/cdc_req_sched.sv
// Single-outstanding request scheduler in front of a CDC TX/RX bridge pair.
// Round-robin grant, response timeout, and discard of late (stale) responses.
module cdc_req_sched #(
  parameter int NREQ    = 4,
  parameter int REQ_DW  = 41,
  parameter int RSP_DW  = 34,
  parameter int TIMEOUT = 1024,
  parameter int DROP_CW = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_vld,
  output logic [NREQ-1:0]            req_rdy,
  input  logic [NREQ*REQ_DW-1:0]     req_dat,
  output logic [NREQ-1:0]            rsp_vld,
  input  logic [NREQ-1:0]            rsp_rdy,
  output logic [RSP_DW-1:0]          rsp_dat,
  output logic                       rsp_err,
  output logic                       tx_vld,
  input  logic                       tx_rdy,
  output logic [REQ_DW-1:0]          tx_dat,
  input  logic                       rx_vld,
  output logic                       rx_rdy,
  input  logic [RSP_DW-1:0]          rx_dat,
  output logic                       busy,
  output logic [$clog2(NREQ)-1:0]    gnt_id
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_DLVR
  } state_t;

  state_t              r_state;
  logic [IW-1:0]       r_last;
  logic [IW-1:0]       r_gnt;
  logic [TW-1:0]       r_timer;
  logic [DROP_CW-1:0]  r_drop;
  logic [REQ_DW-1:0]   r_tx_dat;
  logic [RSP_DW-1:0]   r_rsp_dat;
  logic                r_rsp_err;

  logic [IW:0]         w_sum;
  logic [IW-1:0]       w_idx;
  logic [IW-1:0]       w_win;
  logic                w_any;
  logic                w_sat;
  logic                w_dnz;
  logic                w_grant;
  logic                w_stale;
  logic                w_rsp_ok;
  logic                w_expire;

  // Search starts just after the last owner and wraps modulo NREQ.
  always_comb begin
    w_sum = '0;
    w_idx = '0;
    w_win = '0;
    w_any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_sum = {1'b0, r_last} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NREQ))
        w_idx = IW'(w_sum - (IW+1)'(NREQ));
      else
        w_idx = IW'(w_sum);
      if (!w_any && req_vld[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_sat    = &r_drop;
  assign w_dnz    = |r_drop;
  assign w_grant  = !rst && (r_state == S_IDLE) && w_any && !w_sat;
  assign w_stale  = rx_vld && w_dnz;
  assign w_rsp_ok = (r_state == S_WAIT) && rx_vld && !w_dnz;
  // A genuine response arriving on the last timer cycle beats the timeout.
  assign w_expire = (TIMEOUT > 0) && (r_state == S_WAIT) &&
                    (r_timer == TW'(TIMEOUT - 1)) && !w_rsp_ok;

  assign req_rdy = w_grant ? (NREQ'(1) << w_win) : '0;
  assign rx_rdy  = (r_state == S_WAIT) || w_dnz;
  assign tx_vld  = (r_state == S_SEND);
  assign tx_dat  = r_tx_dat;
  assign busy    = (r_state != S_IDLE);
  assign gnt_id  = r_gnt;
  assign rsp_dat = r_rsp_dat;
  assign rsp_err = r_rsp_err;
  assign rsp_vld = (r_state == S_DLVR) ? (NREQ'(1) << r_gnt) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_last    <= IW'(NREQ - 1);
      r_gnt     <= '0;
      r_timer   <= '0;
      r_drop    <= '0;
      r_tx_dat  <= '0;
      r_rsp_dat <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (w_expire && !w_stale && !w_sat)
        r_drop <= r_drop + 1'b1;
      else if (w_stale && !w_expire)
        r_drop <= r_drop - 1'b1;

      unique case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_tx_dat <= req_dat[w_win*REQ_DW +: REQ_DW];
            r_gnt    <= w_win;
            r_state  <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_rdy) begin
            r_timer <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (w_rsp_ok) begin
            r_rsp_dat <= rx_dat;
            r_rsp_err <= 1'b0;
            r_state   <= S_DLVR;
          end else if (w_expire) begin
            r_rsp_dat <= '0;
            r_rsp_err <= 1'b1;
            r_state   <= S_DLVR;
          end
        end
        S_DLVR: begin
          if (rsp_rdy[r_gnt]) begin
            r_last  <= r_gnt;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_req_sched.sv
// Randomized transaction-level bench for cdc_req_sched.
// Reference model: round-robin pick, stale-beat count, timeout window.
module tb_cdc_req_sched;

  localparam int NREQ   = 4;
  localparam int REQ_DW = 41;
  localparam int RSP_DW = 34;
  localparam int TMO    = 8;
  localparam int DCW    = 2;
  localparam int DSAT   = (1 << DCW) - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_vld;
  logic [NREQ-1:0]        req_rdy;
  logic [NREQ*REQ_DW-1:0] req_dat;
  logic [NREQ-1:0]        rsp_vld;
  logic [NREQ-1:0]        rsp_rdy;
  logic [RSP_DW-1:0]      rsp_dat;
  logic                   rsp_err;
  logic                   tx_vld;
  logic                   tx_rdy;
  logic [REQ_DW-1:0]      tx_dat;
  logic                   rx_vld;
  logic                   rx_rdy;
  logic [RSP_DW-1:0]      rx_dat;
  logic                   busy;
  logic [1:0]             gnt_id;

  cdc_req_sched #(
    .NREQ(NREQ), .REQ_DW(REQ_DW), .RSP_DW(RSP_DW),
    .TIMEOUT(TMO), .DROP_CW(DCW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_dat(req_dat),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .tx_vld(tx_vld), .tx_rdy(tx_rdy), .tx_dat(tx_dat),
    .rx_vld(rx_vld), .rx_rdy(rx_rdy), .rx_dat(rx_dat),
    .busy(busy), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;
  int m_last;
  int m_drop;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    int j;
    for (int k = 1; k <= NREQ; k++) begin
      j = (last + k) % NREQ;
      if (((v >> j) & NREQ'(1)) != '0) return j;
    end
    return 0;
  endfunction

  function automatic logic [RSP_DW-1:0] rnd_rsp();
    return RSP_DW'({$urandom(), $urandom()});
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_txv"}, 64'(tx_vld), 64'(0));
    chk({tag, "_rxr"}, 64'(rx_rdy), 64'(0));
    chk({tag, "_rqr"}, 64'(req_rdy), 64'(0));
    chk({tag, "_rsv"}, 64'(rsp_vld), 64'(0));
    chk({tag, "_bsy"}, 64'(busy), 64'(0));
  endtask

  task automatic drain_idle(input int n);
    for (int i = 0; i < n; i++) begin
      rx_vld = 1'b1;
      rx_dat = rnd_rsp();
      #1;
      chk("drain_rxr", 64'(rx_rdy), 64'(m_drop > 0));
      chk("drain_rsv", 64'(rsp_vld), 64'(0));
      if (m_drop > 0) m_drop--;
      tick();
    end
    rx_vld = 1'b0;
  endtask

  task automatic run_txn(input logic [NREQ-1:0] vld, input int stall,
                         input bit drain, input int lat, input int rdly);
    logic [REQ_DW-1:0] exp_tx;
    logic [RSP_DW-1:0] exp_dat;
    logic [NREQ-1:0]   own;
    int w;
    int nst;
    bit got;
    bit sent;
    w       = rr_pick(vld, m_last);
    own     = NREQ'(1) << w;
    req_dat = (NREQ*REQ_DW)'({$urandom(), $urandom(), $urandom(),
                              $urandom(), $urandom(), $urandom()});
    exp_tx  = req_dat[w*REQ_DW +: REQ_DW];
    exp_dat = '0;
    req_vld = vld;
    #1;
    chk("idle_bsy", 64'(busy), 64'(0));
    chk("grant", 64'(req_rdy), 64'(own));
    chk("idle_rxr", 64'(rx_rdy), 64'(m_drop > 0));
    tick();
    for (int s = 0; s < stall; s++) begin
      tx_rdy = 1'b0;
      #1;
      chk("stall_txv", 64'(tx_vld), 64'(1));
      chk("stall_txd", 64'(tx_dat), 64'(exp_tx));
      chk("stall_rqr", 64'(req_rdy), 64'(0));
      chk("stall_bsy", 64'(busy), 64'(1));
      tick();
    end
    tx_rdy = 1'b1;
    #1;
    chk("send_txv", 64'(tx_vld), 64'(1));
    chk("send_txd", 64'(tx_dat), 64'(exp_tx));
    chk("send_gnt", 64'(gnt_id), 64'(w));
    chk("send_rqr", 64'(req_rdy), 64'(0));
    tick();
    tx_rdy = 1'b0;
    nst = drain ? m_drop : 0;
    got = 1'b0;
    for (int k = 0; k < TMO && !got; k++) begin
      sent = 1'b0;
      rx_vld = 1'b0;
      if (k < nst || (lat >= 0 && k == nst + lat)) begin
        rx_vld = 1'b1;
        rx_dat = rnd_rsp();
        sent = 1'b1;
      end
      #1;
      chk("wait_rxr", 64'(rx_rdy), 64'(1));
      chk("wait_rsv", 64'(rsp_vld), 64'(0));
      chk("wait_txv", 64'(tx_vld), 64'(0));
      chk("wait_rqr", 64'(req_rdy), 64'(0));
      if (sent) begin
        if (m_drop > 0) m_drop--;
        else begin
          got = 1'b1;
          exp_dat = rx_dat;
        end
      end
      tick();
    end
    rx_vld = 1'b0;
    if (!got) m_drop++;
    for (int r = 0; r <= rdly; r++) begin
      if (r == rdly) rsp_rdy = NREQ'($urandom()) | own;
      else rsp_rdy = NREQ'($urandom()) & ~own;
      #1;
      chk("dlvr_rsv", 64'(rsp_vld), 64'(own));
      chk("dlvr_err", 64'(rsp_err), 64'(!got));
      chk("dlvr_dat", 64'(rsp_dat), 64'(exp_dat));
      chk("dlvr_rxr", 64'(rx_rdy), 64'(m_drop > 0));
      chk("dlvr_rqr", 64'(req_rdy), 64'(0));
      tick();
    end
    rsp_rdy = '0;
    req_vld = '0;
    m_last  = w;
    #1;
    chk("done_bsy", 64'(busy), 64'(0));
    chk("done_rsv", 64'(rsp_vld), 64'(0));
  endtask

  initial begin
    rst     = 1'b1;
    req_vld = '0;
    req_dat = '0;
    rsp_rdy = '0;
    tx_rdy  = 1'b0;
    rx_vld  = 1'b0;
    rx_dat  = '0;
    tick();
    tick();
    req_vld = '1;
    #1;
    chk_quiet("rst");
    chk("rst_gnt", 64'(gnt_id), 64'(0));
    chk("rst_txd", 64'(tx_dat), 64'(0));
    chk("rst_rsd", 64'(rsp_dat), 64'(0));
    chk("rst_err", 64'(rsp_err), 64'(0));
    req_vld = '0;
    rst = 1'b0;
    m_last = NREQ - 1;
    m_drop = 0;
    tick();

    for (int i = 0; i < 5; i++) run_txn(4'b1111, 0, 1'b1, 0, 0);
    run_txn(4'b0100, 5, 1'b1, 1, 0);

    run_txn(4'b1000, 0, 1'b1, -1, 0);
    #1;
    chk("late_rxr", 64'(rx_rdy), 64'(1));
    run_txn(4'b0001, 0, 1'b1, 2, 1);
    #1;
    chk("clr_rxr", 64'(rx_rdy), 64'(0));

    run_txn(4'b0010, 0, 1'b1, TMO - 1, 0);

    for (int i = 0; i < 3; i++) run_txn(4'b0001, 1, 1'b0, -1, 0);
    req_vld = '1;
    #1;
    chk("sat_rqr", 64'(req_rdy), 64'(0));
    chk("sat_rxr", 64'(rx_rdy), 64'(1));
    tick();
    chk("sat_bsy", 64'(busy), 64'(0));
    req_vld = '0;
    drain_idle(DSAT);
    #1;
    chk("unsat_rxr", 64'(rx_rdy), 64'(0));

    for (int i = 0; i < 40; i++) begin
      if (m_drop >= DSAT) drain_idle(m_drop);
      run_txn(NREQ'($urandom_range(1, 15)), $urandom_range(0, 3),
              $urandom_range(0, 3) != 0,
              ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 9),
              $urandom_range(0, 2));
    end

    req_vld = 4'b0100;
    tick();
    req_vld = '0;
    tx_rdy = 1'b1;
    tick();
    tx_rdy = 1'b0;
    tick();
    chk("pre_rst_bsy", 64'(busy), 64'(1));
    rst = 1'b1;
    tick();
    req_vld = '1;
    #1;
    chk_quiet("mid_rst");
    req_vld = '0;
    rst = 1'b0;
    m_last = NREQ - 1;
    m_drop = 0;
    #1;
    chk_quiet("post_rst");
    run_txn(4'b1111, 0, 1'b1, 3, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/cdc_req_sched.md
CDC_REQ_SCHED -- requirements
Module: cdc_req_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter REQ_DW, default 41, request payload width.
REQ-003 SHALL have parameter RSP_DW, default 34, response payload width.
REQ-004 SHALL have parameter TIMEOUT, default 1024, response timeout in cycles; 0 disables timeout.
REQ-005 SHALL have parameter DROP_CW, default 2, width of the stale-response counter.
REQ-006 SHALL have one clock and a synchronous, active-high reset, ports named clk and rst.
REQ-007 clk  in  1  sole clock; all state on rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 req_vld  in  NREQ  per-requester request valid.
REQ-010 req_rdy  out  NREQ  per-requester request accept.
REQ-011 req_dat  in  NREQ*REQ_DW  requester i payload at bits [i*REQ_DW +: REQ_DW].
REQ-012 rsp_vld  out  NREQ  response valid, one-hot to the owning requester.
REQ-013 rsp_rdy  in  NREQ  per-requester response accept.
REQ-014 rsp_dat  out  RSP_DW  response payload, shared by all requesters.
REQ-015 rsp_err  out  1  response is a timeout error, qualified by rsp_vld.
REQ-016 tx_vld / tx_rdy / tx_dat  out / in / out  1/1/REQ_DW  valid/ready request channel to the CDC TX bridge.
REQ-017 rx_vld / rx_rdy / rx_dat  in / out / in  1/1/RSP_DW  valid/ready response channel from the CDC RX bridge.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 gnt_id  out  $clog2(NREQ)  index of the current owner; valid when busy=1.

Function
REQ-020 SHALL implement FSM states IDLE, SEND, WAIT, DLVR, with one transaction in flight at a time.
REQ-021 In IDLE with any req_vld=1 and drop_cnt not saturated, SHALL pick winner w by round-robin.
- Search starts at (last_gnt+1) mod NREQ.
- req_rdy[w]=1 combinationally in the same cycle; all other req_rdy=0.
- Edge actions: capture req_dat[w] into tx_dat, set gnt_id=w, go to SEND.
REQ-022 req_rdy SHALL be all-zero outside IDLE and whenever drop_cnt is saturated.
REQ-023 In SEND, tx_vld SHALL be 1 and tx_dat SHALL be held stable.
- On tx_vld&tx_rdy: go to WAIT and clear the timer.
- tx_vld is first high exactly 1 cycle after the req handshake.
REQ-024 In WAIT, rx_rdy SHALL be 1 and the timer SHALL increment each cycle.
- rx_vld with drop_cnt=0: capture rx_dat into rsp_dat, set rsp_err=0, go to DLVR.
REQ-025 In WAIT with TIMEOUT>0, if the timer equals TIMEOUT-1 and no response is accepted that cycle:
- set rsp_err=1 and rsp_dat=0;
- increment drop_cnt;
- go to DLVR.
REQ-026 If a genuine response and timer expiry occur in the same cycle, the response SHALL win: no error, no drop_cnt increment.
REQ-027 While drop_cnt>0, rx_rdy SHALL be 1 in every state.
- Each accepted rx beat decrements drop_cnt and is discarded, never delivered.
- In WAIT, such a beat does not end the wait and does not reset the timer.
REQ-028 A simultaneous drop_cnt increment and decrement SHALL leave drop_cnt unchanged; drop_cnt never wraps.
REQ-029 In DLVR, rsp_vld[gnt_id] SHALL be 1.
- On rsp_rdy[gnt_id]: set last_gnt=gnt_id, go to IDLE.
- rsp_dat and rsp_err stay stable until then.
REQ-030 rx_rdy SHALL be 0 in IDLE, SEND and DLVR unless drop_cnt>0.
REQ-031 A requester SHALL NOT be re-granted until its response has been accepted; a new grant is possible the cycle after DLVR completes.

Reset
REQ-032 When rst=1 at a clk edge, the block SHALL set:
- state=IDLE, last_gnt=NREQ-1, gnt_id=0;
- timer=0, drop_cnt=0;
- tx_dat=0, rsp_dat=0, rsp_err=0.
REQ-033 During and after reset, all outputs SHALL be 0: tx_vld, rx_rdy, req_rdy, rsp_vld, busy.
REQ-034 A reset mid-transaction SHALL abort it without delivering a response; in-flight CDC traffic is discarded by the CDC bridges' own reset.

Verification
REQ-035 After reset, req_vld=4'b1111 with single-cycle tx_rdy and rx_vld, all rsp_rdy=1 -> grants in order 0,1,2,3,0; each rsp_dat equals the rx_dat returned for that request.
REQ-036 Only req 2 valid; tx_rdy held low 5 cycles -> tx_vld high 6 cycles with tx_dat constant; busy=1; req_rdy=0 throughout.
REQ-037 TIMEOUT=8, rx_vld never asserted -> rsp_vld[w] with rsp_err=1 and rsp_dat=0 exactly 8 cycles after entering WAIT; drop_cnt=1.
REQ-038 Continue from the timeout case, then rx_vld a late beat followed by the next request's beat -> late beat consumed with no rsp_vld; next response delivered correctly; drop_cnt=0.
REQ-039 rx_vld coincident with timer=TIMEOUT-1 -> rsp_err=0, rsp_dat=rx_dat, drop_cnt unchanged.
REQ-040 rst=1 pulsed while in WAIT -> the next cycle has all outputs zero and busy=0; the next request is granted starting from index 0.
